stim_seq_ctrl: RTL and testbench

Self-contained stimulus sequencer and response compactor for a fuzz-target `top` with flat ports (in_flat/out_flat). It generates input vectors with the team's deterministic 32-bit LCG, one 32-bit chunk per clock, and applies each completed vector atomically. It sequences a programmable number of vectors and folds the DUT response into a 32-bit MISR signature, giving an on-chip equivalent of the bench stimulus loop for emulation and cross-simulator signature compares.

---
 rtl/stim_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stim_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stim_seq_ctrl.sv
// LCG stimulus sequencer with MISR response compaction for a flat-port fuzz target.
// Optional build macro STIM_SEQ_HOLD_EN adds a `hold` input that freezes the sequencer.
module stim_seq_ctrl #(
    parameter int          IN_W      = 139,
    parameter int          OUT_W     = 159,
    parameter logic [31:0] MISR_POLY = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [31:0]      cycles,
`ifdef STIM_SEQ_HOLD_EN
    input  logic             hold,
`endif
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [31:0]      vec_count,
    output logic [31:0]      signature
);

    localparam int NCHUNK = (IN_W + 31) / 32;
    localparam int CIW    = $clog2(NCHUNK + 1);

    localparam logic [CIW-1:0] LAST_CHUNK = CIW'(NCHUNK - 1);
    localparam logic [CIW-1:0] DRAIN_LAST = CIW'(NCHUNK);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_APPLY = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * 32'h41C64E6D + 32'h00003039;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] f);
        return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h00000000) ^ f;
    endfunction

    logic [2:0]      state_r;
    logic [31:0]     rng_r;
    logic [31:0]     cyc_r;
    logic [CIW-1:0]  chunk_idx_r;
    logic [CIW-1:0]  drain_cnt_r;
    logic [IN_W-1:0] shadow_r;
    logic [IN_W-1:0] dut_in_r;
    logic            busy_r;
    logic            done_r;
    logic [31:0]     vec_count_r;
    logic [31:0]     signature_r;

    logic            hold_s;
    logic [31:0]     rng_next_s;
    logic [31:0]     vec_inc_s;
    logic [31:0]     fold_s;

`ifdef STIM_SEQ_HOLD_EN
    assign hold_s = hold;
`else
    assign hold_s = 1'b0;
`endif

    assign rng_next_s = lcg(rng_r);
    assign vec_inc_s  = vec_count_r + 32'd1;

    // XOR-fold the response into one word; the top slice is implicitly zero-padded.
    always_comb begin
        fold_s = 32'h00000000;
        for (int b = 0; b < OUT_W; b++) begin
            fold_s[b % 32] = fold_s[b % 32] ^ dut_out[b];
        end
    end

    // Sequencer FSM: fill shadow chunk by chunk, apply atomically, then drain the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            rng_r       <= 32'h00000000;
            cyc_r       <= 32'h00000000;
            chunk_idx_r <= '0;
            drain_cnt_r <= '0;
            shadow_r    <= '0;
            dut_in_r    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            vec_count_r <= 32'h00000000;
            signature_r <= 32'hFFFFFFFF;
        end else if (!hold_s) begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rng_r       <= seed;
                        cyc_r       <= cycles;
                        chunk_idx_r <= '0;
                        vec_count_r <= 32'h00000000;
                        signature_r <= 32'hFFFFFFFF;
                        done_r      <= 1'b0;
                        if (cycles == 32'h00000000) begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    rng_r <= rng_next_s;
                    for (int b = 0; b < IN_W; b++) begin
                        if ((b / 32) == int'(chunk_idx_r)) begin
                            shadow_r[b] <= rng_next_s[b % 32];
                        end
                    end
                    if (chunk_idx_r == LAST_CHUNK) begin
                        chunk_idx_r <= '0;
                        state_r     <= S_APPLY;
                    end else begin
                        chunk_idx_r <= chunk_idx_r + CIW'(1);
                    end
                end
                S_APPLY: begin
                    // The response on dut_out belongs to the previous vector, so skip it for the first one.
                    if (vec_count_r != 32'h00000000) begin
                        signature_r <= misr_step(signature_r, fold_s);
                    end
                    dut_in_r    <= shadow_r;
                    vec_count_r <= vec_inc_s;
                    if (vec_inc_s == cyc_r) begin
                        drain_cnt_r <= '0;
                        state_r     <= S_DRAIN;
                    end else begin
                        state_r     <= S_FILL;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        signature_r <= misr_step(signature_r, fold_s);
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + CIW'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_in    = dut_in_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign vec_count = vec_count_r;
    assign signature = signature_r;

endmodule

// File: tb/tb_stim_seq_ctrl.sv
// Scoreboard bench for stim_seq_ctrl: a behavioural model queues every expected vector and signature.
module tb_stim_seq_ctrl;

    localparam int IN_W   = 139;
    localparam int OUT_W  = 159;
    localparam int NCHUNK = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      seed = 32'h0;
    logic [31:0]      cycles = 32'h0;
    logic             hold = 1'b0;
    logic             stub_zero = 1'b0;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic [31:0]      vec_count;
    logic [31:0]      signature;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int held = 0;
    logic [IN_W-1:0] exp_vec_q[$];

    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * 32'h41C64E6D + 32'h00003039;
    endfunction

    function automatic logic [OUT_W-1:0] resp(input logic [IN_W-1:0] v);
        return {v, v[19:0] ^ 20'hA5A5A};
    endfunction

    function automatic logic [31:0] fold(input logic [OUT_W-1:0] o);
        logic [159:0] p;
        p = {1'b0, o};
        return p[31:0] ^ p[63:32] ^ p[95:64] ^ p[127:96] ^ p[159:128];
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] f);
        return (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    assign dut_out = stub_zero ? '0 : resp(dut_in);

    stim_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .cycles    (cycles),
`ifdef STIM_SEQ_HOLD_EN
        .hold      (hold),
`endif
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .vec_count (vec_count),
        .signature (signature)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (hold && busy) held <= held + 1;
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every vec_count step pops the next expected vector and checks the apply cadence.
    initial begin
        logic [31:0] prev_cnt;
        int last_apply;
        int held_base;
        prev_cnt = 32'h0;
        last_apply = 0;
        held_base = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cnt = 32'h0;
            end else if (vec_count != prev_cnt) begin
                if (vec_count != 32'h0) begin
                    if (exp_vec_q.size() == 0) begin
                        check_val("sb_empty", 256'(exp_vec_q.size()), 256'd1);
                    end else begin
                        check_val("dut_in", 256'(dut_in), 256'(exp_vec_q.pop_front()));
                        if (prev_cnt != 32'h0)
                            check_val("cadence", 256'(edge_cnt - last_apply), 256'(NCHUNK + 1 + held - held_base));
                    end
                    last_apply = edge_cnt;
                    held_base = held;
                end
                prev_cnt = vec_count;
            end
        end
    end

    task automatic model_push(input logic [31:0] s, input logic [31:0] n,
                              output logic [31:0] sig, output logic [IN_W-1:0] lastv);
        logic [31:0] r;
        logic [IN_W-1:0] v, t;
        r = s;
        sig = 32'hFFFFFFFF;
        lastv = '0;
        for (int k = 0; k < int'(n); k++) begin
            v = '0;
            for (int c = 0; c < NCHUNK; c++) begin
                r = lcg(r);
                t = IN_W'(r);
                v = v | (t << (32 * c));
            end
            exp_vec_q.push_back(v);
            sig = misr(sig, stub_zero ? 32'h0 : fold(resp(v)));
            lastv = v;
        end
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] n, input int hold_at,
                       input bit poke, output logic [IN_W-1:0] lastv);
        logic [31:0] sig;
        int k, lat, nheld;
        model_push(s, n, sig, lastv);
        nheld = 0;
        @(negedge clk);
        seed = s; cycles = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0; seed = $urandom; cycles = $urandom;
        k = 1;
        while (!done && k < 2000) begin
            if (poke && k == 3) begin start = 1'b1; seed = s ^ 32'h1; cycles = 32'd1; end
            if (poke && k == 4) start = 1'b0;
            if (hold_at > 0 && k == hold_at) begin hold = 1'b1; nheld = 3; end
            if (hold_at > 0 && k == hold_at + 3) hold = 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        hold = 1'b0;
        lat = (n == 32'h0) ? 1 : (NCHUNK + 1) * (int'(n) + 1) + 1 + nheld;
        check_val("done_latency", 256'(k), 256'(lat));
        check_val("done", 256'(done), 256'd1);
        check_val("busy_end", 256'(busy), 256'd0);
        check_val("vec_count", 256'(vec_count), 256'(n));
        check_val("signature", 256'(signature), 256'(sig));
        check_val("sb_drained", 256'(exp_vec_q.size()), 256'd0);
    endtask

    initial begin
        logic [IN_W-1:0] lastv, prevv;
        logic [31:0] sig5;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 256'(busy), 256'd0);
        check_val("rst_done", 256'(done), 256'd0);
        check_val("rst_dut_in", 256'(dut_in), 256'd0);
        check_val("rst_vec_count", 256'(vec_count), 256'd0);
        check_val("rst_signature", 256'(signature), 256'hFFFFFFFF);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("idle_busy", 256'(busy), 256'd0);
        check_val("idle_dut_in", 256'(dut_in), 256'd0);
        check_val("idle_signature", 256'(signature), 256'hFFFFFFFF);

        // First vector from seed 0 against hand-computed LCG words.
        run(32'h0, 32'd1, 0, 1'b0, lastv);
        check_val("chunk0", 256'(dut_in[31:0]), 256'h00003039);
        check_val("chunk1", 256'(dut_in[63:32]), 256'hD3DC167E);

        stub_zero = 1'b1;
        run(32'h0, 32'd2, 0, 1'b0, lastv);
        stub_zero = 1'b0;
        prevv = lastv;

        run(32'h12345678, 32'd0, 0, 1'b0, lastv);
        check_val("zero_run_dut_in", 256'(dut_in), 256'(prevv));

        run(32'hCAFEF00D, 32'd5, 0, 1'b1, lastv);

        // Reset in the middle of a run, then restart with the same seed.
        model_push(32'hCAFEF00D, 32'd5, sig5, lastv);
        @(negedge clk);
        seed = 32'hCAFEF00D; cycles = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 256'(busy), 256'd0);
        check_val("mid_rst_dut_in", 256'(dut_in), 256'd0);
        check_val("mid_rst_vec_count", 256'(vec_count), 256'd0);
        check_val("mid_rst_signature", 256'(signature), 256'hFFFFFFFF);
        exp_vec_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(32'hCAFEF00D, 32'd5, 0, 1'b0, lastv);

`ifdef STIM_SEQ_HOLD_EN
        run(32'd7, 32'd2, 2, 1'b0, lastv);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
